i2c_target_regfile: RTL
=======================

Name: i2c_target_regfile

Overview:
- Soft, parametrised I2C target (slave) built in fabric.
- Successor to the hard-IP I2C wrapper: configurable address, register depth, input synchroniser length and glitch filter.
- Supports auto-incrementing register-pointer reads/writes, repeated start, and a local fabric bus port onto the same register file.
- Sits between the board I2C pins (open-drain via top-level tristate) and Sobel pipeline control/status logic.

Parameters:
- ADDR_P, 7'h42, 7-bit target address matched against the address byte.
- DEPTH_P, 16, number of 8-bit registers; power of two, 2..256; AW = clog2(DEPTH_P).
- SYNC_STAGES_P, 2, flops in the scl_i/sda_i synchronisers (>=2).
- FILTER_P, 3, consecutive identical synchronised samples required before a filtered SCL/SDA level changes (>=1).

Ports:
- clk_i  in  1  system clock; must be >= 16x SCL frequency.
- reset_i  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_oe_o  out  1  1 = pull SDA low (top level drives 0 when set, else Z).
- bus_valid_i  in  1  local bus request.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_i  in  AW  local register index.
- bus_wdata_i  in  8  local write data.
- bus_ready_o  out  1  request accepted this cycle.
- bus_rdata_o  out  8  read data, valid when bus_rvalid_o.
- bus_rvalid_o  out  1  one-cycle pulse, the cycle after an accepted read.
- wr_irq_o  out  1  one-cycle pulse per I2C data byte committed.
- busy_o  out  1  high while addressed (address ACK through STOP or mismatched repeated start).

Behaviour:
- Reset (asynchronous):
  - sda_oe_o, bus_rvalid_o, wr_irq_o, busy_o = 0; bus_rdata_o = 0.
  - All registers = 0; pointer = 0; state = IDLE; filtered SCL/SDA = 1.
  - Reset mid-transaction releases SDA immediately, with no clock needed.
- Front end:
  - Synchroniser followed by the FILTER_P-sample filter.
  - Pin-to-edge latency is SYNC_STAGES_P + FILTER_P cycles.
  - SCL rise/fall edges and START/STOP events are single-cycle strobes.
- Events:
  - START = filtered SDA falls while filtered SCL is high.
  - STOP = filtered SDA rises while filtered SCL is high.
  - START in any state -> ADDR with bit count cleared; pointer retained (repeated start).
  - STOP in any state -> IDLE with SDA released.
  - START/STOP take priority over a same-cycle SCL edge.
- Data sampling and driving:
  - Data bits are sampled on filtered SCL rise, MSB first.
  - sda_oe_o changes only on filtered SCL fall, apart from START/STOP/reset.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RMACK, IGNORE.
- ADDR:
  - After 8 bits, compare the top 7 bits with ADDR_P.
  - Match: ACK (sda_oe_o = 1 from the 8th SCL fall to the 9th SCL fall); busy_o = 1.
  - R/W = 0 -> PTR; R/W = 1 -> RDATA.
  - Mismatch -> IGNORE, SDA untouched until START/STOP.
- Write path:
  - PTR: received byte's low AW bits load the pointer; ACK.
  - WDATA: each byte is written to reg[pointer] on the 8th SCL rise, wr_irq_o pulses, then ACK.
  - Pointer increments modulo DEPTH_P (wraps DEPTH_P-1 -> 0).
- Read path:
  - On the ADDR_ACK end fall, the shifter loads reg[pointer].
  - Each bit is driven as sda_oe_o = ~bit.
  - After 8 bits SDA is released; the master ACK/NACK is sampled on the 9th rise.
  - ACK: pointer++ (wrap), next byte loaded on the 9th fall.
  - NACK -> IGNORE.
- Local bus:
  - bus_ready_o = 1 except in the cycle an I2C write commits (I2C wins).
  - Accepted write updates reg at the clock edge.
  - Accepted read returns data next cycle with a bus_rvalid_o pulse.
  - A local write does not alter the pointer.
  - A local write to the byte currently in the read shifter does not affect bits already loaded.

Test Plan:
1. Write burst: START, 0x84 (addr 0x42 W), 0x03, 0xA5, 0x5A, STOP -> 4 ACKs; reg[3]=0xA5, reg[4]=0x5A; wr_irq_o pulses twice; busy_o low after STOP.
2. Repeated-start read: START, 0x84, 0x03, Sr, 0x85, read 2 bytes (ACK then NACK) -> SDA returns 0xA5, 0x5A; sda_oe_o = 0 after NACK; pointer = 5.
3. Address mismatch: START, 0x86, 0x00, 0xFF, STOP -> sda_oe_o never 1; registers unchanged; busy_o stays 0; wr_irq_o never pulses.
4. Wrap and collision: pointer 0x0F, write 0x11, 0x22, 0x33 -> reg[15]=0x11, reg[0]=0x22, reg[1]=0x33.
   - Local write to addr 0 in the same cycle as the I2C commit -> bus_ready_o = 0 that cycle; reg[0] = 0x22.
   - Retried local read of addr 0 -> bus_rvalid_o next cycle with 0x22.
5. Glitch and reset:
   - A 2-cycle SDA low pulse while SCL is high (FILTER_P=3) -> no START detected.
   - reset_i asserted mid-read while sda_oe_o = 1 -> sda_oe_o = 0 asynchronously; state IDLE; registers = 0.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
//   Soft I2C target with a DEPTH_P x 8-bit register file. The register pointer
//   auto-increments on both reads and writes. A local fabric bus shares the
//   same registers. Sits between the board I2C pins and pipeline control/status.
//
// Ports
//   clk_i, reset_i          system clock (>= 16x SCL), async active-high reset
//   scl_i, sda_i            raw pin levels
//   sda_oe_o                1 = pull SDA low (top level tristate)
//   bus_valid_i, bus_we_i   local request, 1 = write
//   bus_addr_i, bus_wdata_i local register index / write data
//   bus_ready_o             request accepted this cycle (low only on I2C commit)
//   bus_rdata_o, bus_rvalid_o  read data, rvalid pulses the cycle after accept
//   wr_irq_o                one pulse per I2C data byte committed
//   busy_o                  high from address ACK until STOP / mismatched Sr
//
// state      | meaning
// IDLE       | bus free or not yet started
// ADDR       | shifting in address + R/W
// ADDR_ACK   | driving ACK for our address
// PTR        | shifting in register pointer
// PTR_ACK    | driving ACK for pointer byte
// WDATA      | shifting in a data byte (commits on 8th rise)
// WDATA_ACK  | driving ACK for data byte
// RDATA      | driving read byte MSB first
// RMACK      | SDA released, sampling master ACK/NACK
// IGNORE     | not ours / read finished; wait for START or STOP
module i2c_target_regfile #(
  parameter logic [6:0] ADDR_P        = 7'h42,
  parameter int         DEPTH_P       = 16,
  parameter int         SYNC_STAGES_P = 2,
  parameter int         FILTER_P      = 3,
  localparam int        AW            = $clog2(DEPTH_P)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  input  logic          bus_valid_i,
  input  logic          bus_we_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [7:0]    bus_wdata_i,
  output logic          bus_ready_o,
  output logic [7:0]    bus_rdata_o,
  output logic          bus_rvalid_o,
  output logic          wr_irq_o,
  output logic          busy_o
);

  localparam int CW = (FILTER_P > 1) ? $clog2(FILTER_P) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RMACK, IGNORE
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [SYNC_STAGES_P-1:0] sync_q [2];
  logic [CW-1:0]            flt_cnt_q [2];
  logic [1:0]               flt_q, flt_d_q, pin;

  logic       scl_f, sda_f, scl_rise, scl_fall, start_evt, stop_evt;
  logic       i2c_commit;
  logic [7:0] rx_byte;

  state_t        state_q;
  logic [3:0]    bitcnt_q;
  logic [7:0]    sr_q;
  logic [AW-1:0] ptr_q;
  logic          rw_q, mack_q;
  logic [7:0]    regs_q [DEPTH_P];

  assign pin = {sda_i, scl_i};

  // Filtered level flips only after FILTER_P consecutive differing samples.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]    <= '1;
        flt_cnt_q[i] <= '0;
      end
      flt_q   <= 2'b11;
      flt_d_q <= 2'b11;
    end else begin
      flt_d_q <= flt_q;
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES_P-2:0], pin[i]};
        if (sync_q[i][SYNC_STAGES_P-1] == flt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == CW'(FILTER_P - 1)) begin
          flt_q[i]     <= ~flt_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign scl_f     = flt_q[0];
  assign sda_f     = flt_q[1];
  assign scl_rise  = scl_f & ~flt_d_q[0];
  assign scl_fall  = ~scl_f & flt_d_q[0];
  // SCL must have been high in both samples so an SCL edge never doubles as START/STOP.
  assign start_evt = scl_f & flt_d_q[0] & flt_d_q[1] & ~sda_f;
  assign stop_evt  = scl_f & flt_d_q[0] & ~flt_d_q[1] & sda_f;

  assign rx_byte     = {sr_q[6:0], sda_f};
  assign i2c_commit  = (state_q == WDATA) && scl_rise && (bitcnt_q == 4'd7)
                       && !start_evt && !stop_evt;
  assign bus_ready_o = ~i2c_commit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      mack_q   <= 1'b0;
      sda_oe_o <= 1'b0;
      busy_o   <= 1'b0;
      wr_irq_o <= 1'b0;
    end else begin
      wr_irq_o <= i2c_commit;
      if (stop_evt) begin
        state_q  <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else if (start_evt) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_oe_o <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise && bitcnt_q != 4'd8) begin
              sr_q     <= rx_byte;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (state_q == WDATA && bitcnt_q == 4'd7) ptr_q <= ptr_q + AW'(1);
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              bitcnt_q <= '0;
              if (state_q == ADDR) begin
                if (sr_q[7:1] == ADDR_P) begin
                  state_q  <= ADDR_ACK;
                  sda_oe_o <= 1'b1;
                  busy_o   <= 1'b1;
                  rw_q     <= sr_q[0];
                end else begin
                  state_q <= IGNORE;
                  busy_o  <= 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_q    <= sr_q[AW-1:0];
                state_q  <= PTR_ACK;
                sda_oe_o <= 1'b1;
              end else begin
                state_q  <= WDATA_ACK;
                sda_oe_o <= 1'b1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bitcnt_q <= '0;
              if (rw_q) begin
                state_q  <= RDATA;
                sr_q     <= regs_q[ptr_q];
                sda_oe_o <= ~regs_q[ptr_q][7];
              end else begin
                state_q  <= PTR;
                sda_oe_o <= 1'b0;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              state_q  <= WDATA;
              bitcnt_q <= '0;
              sda_oe_o <= 1'b0;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_o <= 1'b0;
                state_q  <= RMACK;
              end else begin
                sr_q     <= {sr_q[6:0], 1'b0};
                sda_oe_o <= ~sr_q[6];
              end
            end
          end
          RMACK: begin
            // Pointer advances on ACK and NACK alike; it tracks bytes sent.
            if (scl_rise) begin
              mack_q <= ~sda_f;
              ptr_q  <= ptr_q + AW'(1);
            end else if (scl_fall) begin
              if (mack_q) begin
                state_q  <= RDATA;
                bitcnt_q <= '0;
                sr_q     <= regs_q[ptr_q];
                sda_oe_o <= ~regs_q[ptr_q][7];
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file and local bus; an I2C commit wins over a same-cycle local write.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH_P; i++) regs_q[i] <= '0;
      bus_rdata_o  <= '0;
      bus_rvalid_o <= 1'b0;
    end else begin
      if (i2c_commit) begin
        regs_q[ptr_q] <= rx_byte;
      end else if (bus_valid_i && bus_we_i) begin
        regs_q[bus_addr_i] <= bus_wdata_i;
      end
      bus_rvalid_o <= bus_valid_i && !bus_we_i && bus_ready_o;
      if (bus_valid_i && !bus_we_i && bus_ready_o) bus_rdata_o <= regs_q[bus_addr_i];
    end
  end

endmodule
